switch_debouncer: RTL and testbench
===================================

// Module: switch_debouncer
// PURPOSE
//  Conditions raw slide-switch/button pins before they reach the GPI core's din bus.
//  Per bit it provides:
//   - an N-flop synchroniser into clk;
//   - a debounce counter, so only a level held stable for DB_TICKS cycles propagates;
//   - one-cycle rise/fall event pulses.
//  Sits between the FPGA pads and the GPI slot.
// PARAMETERS
//  W           8        number of independent input bits
//  SYNC_STAGES 2        synchroniser depth, legal range 2..4
//  DB_TICKS    2000000  stable cycles required before a change is accepted (20 ms @ 100 MHz), >=2
//  RESET_VAL   '0       W-bit value of db_out while/after reset
// PORTS
//  clk      in   1  system clock, all logic on rising edge
//  reset    in   1  asynchronous, active-low reset (0 = reset asserted)
//  raw_in   in   W  asynchronous pad inputs, may bounce
//  db_out   out  W  debounced, synchronised level; drives GPI din
//  rise     out  W  1-cycle pulse when db_out[i] goes 0->1
//  fall     out  W  1-cycle pulse when db_out[i] goes 1->0
//  busy     out  1  OR of all per-bit PENDING states
// BEHAVIOUR
//  Reset (reset==0, async):
//   - sync chain and counters go to 0; per-bit state is STABLE.
//   - db_out = RESET_VAL; rise = fall = 0; busy = 0.
//  Synchroniser: raw_in[i] shifts through SYNC_STAGES flops; s[i] is the last stage.
//  Counter: cnt[i] is $clog2(DB_TICKS) bits wide and never wraps.
//  Per-bit FSM, 2 states:
//   STABLE:  s==db_out -> stay, cnt=0.
//            s!=db_out -> PENDING, cnt=1.
//   PENDING: s==db_out (bounce back) -> STABLE, cnt=0, no output change.
//            s!=db_out and cnt<DB_TICKS-1 -> cnt++.
//            s!=db_out and cnt==DB_TICKS-1 -> db_out[i]<=s, cnt=0, STABLE,
//              and rise[i] or fall[i] pulsed on the same edge.
//  Latency: raw_in[i] first sampled at a new level on edge 1 and held there
//   -> db_out[i] updates on edge SYNC_STAGES+DB_TICKS.
//  Glitches: any glitch shorter than DB_TICKS cycles (after sync) produces no db_out change
//   and no pulse. A bounce restarts the count from zero.
//  rise/fall:
//   - registered; high exactly one cycle per accepted transition;
//   - never both high for the same bit;
//   - independent across bits, so several bits may pulse in the same cycle.
//  busy: registered, =1 in any cycle where at least one bit is PENDING.
//  Reset release:
//   - if a pad sits at !RESET_VAL[i], that bit debounces normally;
//   - it then emits its rise/fall pulse at edge SYNC_STAGES+DB_TICKS after release.
//  Reset mid-count: the count is discarded immediately; no pulse is emitted.
//  Bits are fully independent; no shared prescaler.
// TESTING  (W=4, SYNC_STAGES=2, DB_TICKS=8, RESET_VAL=0)
//  1 Reset with raw_in=4'hF -> during reset db_out=0, rise=fall=0.
//    After release: db_out=4'hF at edge 10, rise=4'hF for that one cycle only.
//  2 raw_in[0] 0->1 held -> db_out[0]=1 at edge 10, rise[0] 1 cycle, busy high edges 3..9.
//  3 raw_in[1] toggles every 3 cycles for 60 cycles -> db_out[1] never changes, no pulses.
//    Then hold 1 for 10 cycles -> rise[1] once.
//  4 raw_in[2] high 7 cycles then low (one short) -> no change.
//    Repeat with 8 cycles -> db_out[2]=1, and after the later low has been stable -> fall[2] once.
//  5 raw_in=4'b0101->4'b1010 on one edge -> at edge 10: rise=4'b1010, fall=4'b0101, same cycle.
//  6 Assert reset at edge 5 of a pending change -> db_out stays RESET_VAL, no pulse.
//    The change is re-debounced in full after release.

Source files
------------

// File: rtl/switch_debouncer.sv
// switch_debouncer: conditions raw pad inputs before they reach the GPI din bus.
// Each bit passes through a synchroniser and a two-state debounce FSM. The FSM
// accepts a new level only after it has been held stable for DB_TICKS cycles.
// Registered rise/fall pulses mark each accepted transition.
module switch_debouncer #(
  parameter int           W           = 8,
  parameter int           SYNC_STAGES = 2,
  parameter int           DB_TICKS    = 2000000,
  parameter logic [W-1:0] RESET_VAL   = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] raw_in,
  output logic [W-1:0] db_out,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall,
  output logic         busy
);

  // Counter holds 0..DB_TICKS-1, so it never needs to wrap.
  localparam int            CW       = (DB_TICKS > 2) ? $clog2(DB_TICKS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_TICKS - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } db_state_e;

  logic [W-1:0]  sync_r    [SYNC_STAGES];
  logic [W-1:0]  s_s;

  db_state_e     state_r   [W];
  db_state_e     state_nxt [W];
  logic [CW-1:0] cnt_r     [W];
  logic [CW-1:0] cnt_nxt   [W];

  logic [W-1:0]  db_r;
  logic [W-1:0]  rise_r;
  logic [W-1:0]  fall_r;
  logic          busy_r;

  logic [W-1:0]  accept_s;
  logic [W-1:0]  db_nxt;
  logic [W-1:0]  rise_nxt;
  logic [W-1:0]  fall_nxt;
  logic [W-1:0]  pend_nxt;

  // Shift the asynchronous pads through the synchroniser chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_r[k] <= '0;
      end
    end else begin
      sync_r[0] <= raw_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_r[k] <= sync_r[k-1];
      end
    end
  end

  assign s_s = sync_r[SYNC_STAGES-1];

  // State register: per-bit FSM state, counters and the registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < W; i++) begin
        state_r[i] <= ST_STABLE;
        cnt_r[i]   <= '0;
      end
      db_r   <= RESET_VAL;
      rise_r <= '0;
      fall_r <= '0;
      busy_r <= 1'b0;
    end else begin
      for (int i = 0; i < W; i++) begin
        state_r[i] <= state_nxt[i];
        cnt_r[i]   <= cnt_nxt[i];
      end
      db_r   <= db_nxt;
      rise_r <= rise_nxt;
      fall_r <= fall_nxt;
      busy_r <= |pend_nxt;
    end
  end

  // Next-state logic: start, extend, abandon or complete a pending change.
  always_comb begin
    for (int i = 0; i < W; i++) begin
      state_nxt[i] = state_r[i];
      cnt_nxt[i]   = cnt_r[i];
      case (state_r[i])
        ST_STABLE: begin
          if (s_s[i] != db_r[i]) begin
            state_nxt[i] = ST_PENDING;
            cnt_nxt[i]   = CNT_ONE;
          end else begin
            state_nxt[i] = ST_STABLE;
            cnt_nxt[i]   = '0;
          end
        end
        ST_PENDING: begin
          if (s_s[i] == db_r[i]) begin
            // Bounced back before the hold time: discard the count.
            state_nxt[i] = ST_STABLE;
            cnt_nxt[i]   = '0;
          end else if (cnt_r[i] == CNT_LAST) begin
            state_nxt[i] = ST_STABLE;
            cnt_nxt[i]   = '0;
          end else begin
            state_nxt[i] = ST_PENDING;
            cnt_nxt[i]   = cnt_r[i] + CNT_ONE;
          end
        end
        default: begin
          state_nxt[i] = ST_STABLE;
          cnt_nxt[i]   = '0;
        end
      endcase
    end
  end

  // Output logic: commit accepted levels, generate edge pulses and busy.
  always_comb begin
    accept_s = '0;
    db_nxt   = db_r;
    rise_nxt = '0;
    fall_nxt = '0;
    pend_nxt = '0;
    for (int i = 0; i < W; i++) begin
      accept_s[i] = (state_r[i] == ST_PENDING) && (s_s[i] != db_r[i]) &&
                    (cnt_r[i] == CNT_LAST);
      if (accept_s[i]) begin
        db_nxt[i]   = s_s[i];
        rise_nxt[i] = s_s[i];
        fall_nxt[i] = ~s_s[i];
      end else begin
        db_nxt[i]   = db_r[i];
        rise_nxt[i] = 1'b0;
        fall_nxt[i] = 1'b0;
      end
      pend_nxt[i] = (state_nxt[i] == ST_PENDING);
    end
  end

  assign db_out = db_r;
  assign rise   = rise_r;
  assign fall   = fall_r;
  assign busy   = busy_r;

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer (W=4, SYNC_STAGES=2, DB_TICKS=8, RESET_VAL=0).
// Directed scenarios plus a randomized bounce phase. All phases are compared
// each cycle against a sample-history reference model.
module tb_switch_debouncer;

  localparam int           W    = 4;
  localparam int           SYNC = 2;
  localparam int           DB   = 8;
  localparam logic [W-1:0] RV   = 4'h0;

  logic         clk    = 1'b0;
  logic         reset  = 1'b0;
  logic [W-1:0] raw_in = 4'h0;
  logic [W-1:0] db_out;
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  // Reference model: synchroniser modelled as a pipe of samples. A level is
  // accepted once the last DB synced samples, all taken since the last change
  // or reset, disagree with the current output.
  logic [W-1:0]  m_pipe [SYNC];
  logic [DB-1:0] m_hist [W];
  int            m_fresh [W];
  logic [W-1:0]  m_db;
  logic [W-1:0]  m_rise;
  logic [W-1:0]  m_fall;
  logic          m_busy;

  int n_rise;
  int n_fall;
  int hold [W];
  logic [W-1:0] rnd;

  switch_debouncer #(
    .W(W), .SYNC_STAGES(SYNC), .DB_TICKS(DB), .RESET_VAL(RV)
  ) dut (
    .clk(clk), .reset(reset), .raw_in(raw_in),
    .db_out(db_out), .rise(rise), .fall(fall), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < SYNC; k++) m_pipe[k] = '0;
    for (int i = 0; i < W; i++) begin
      m_hist[i]  = '0;
      m_fresh[i] = 0;
    end
    m_db   = RV;
    m_rise = '0;
    m_fall = '0;
    m_busy = 1'b0;
  endtask

  task automatic model_edge(input logic [W-1:0] r);
    logic [W-1:0]  s;
    logic [W-1:0]  old_db;
    logic [DB-1:0] want;
    s      = m_pipe[SYNC-1];
    old_db = m_db;
    m_rise = '0;
    m_fall = '0;
    m_busy = 1'b0;
    for (int i = 0; i < W; i++) begin
      m_hist[i] = {m_hist[i][DB-2:0], s[i]};
      if (m_fresh[i] < DB) m_fresh[i]++;
      want = {DB{~old_db[i]}};
      if (m_fresh[i] >= DB && m_hist[i] == want) begin
        m_db[i]    = s[i];
        m_rise[i]  = s[i];
        m_fall[i]  = ~s[i];
        m_fresh[i] = 0;
      end else if (s[i] != old_db[i]) begin
        m_busy = 1'b1;
      end
    end
    for (int k = SYNC - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
    m_pipe[0] = r;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".db_out"}, db_out, m_db);
    check({tag, ".rise"}, rise, m_rise);
    check({tag, ".fall"}, fall, m_fall);
    check({tag, ".busy"}, {3'b000, busy}, {3'b000, m_busy});
  endtask

  // One clock edge with raw_in applied beforehand; outputs checked 1 ns later.
  task automatic step(input logic [W-1:0] r, input string tag);
    raw_in = r;
    @(posedge clk);
    model_edge(r);
    #1;
    check_all(tag);
    n_rise += int'(rise[1]) + int'(rise[2]);
    n_fall += int'(fall[1]) + int'(fall[2]);
  endtask

  // Assert reset (asynchronously, between edges) for some cycles, then release.
  task automatic do_reset(input logic [W-1:0] r, input int cycles);
    @(negedge clk);
    reset  = 1'b0;
    raw_in = r;
    model_reset();
    #1;
    check("rst.db_out", db_out, RV);
    check("rst.rise", rise, 4'h0);
    check("rst.fall", fall, 4'h0);
    check("rst.busy", {3'b000, busy}, 4'h0);
    repeat (cycles) begin
      @(posedge clk);
      #1;
      check("rst_hold.db_out", db_out, RV);
      check("rst_hold.rise", rise, 4'h0);
      check("rst_hold.busy", {3'b000, busy}, 4'h0);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    n_rise = 0;
    n_fall = 0;
    model_reset();

    // 1: reset with all pads high; accepted at edge 10 after release.
    do_reset(4'hF, 3);
    for (int e = 1; e <= 11; e++) begin
      step(4'hF, "t1");
      check("t1.db_out", db_out, (e >= 10) ? 4'hF : 4'h0);
      check("t1.rise", rise, (e == 10) ? 4'hF : 4'h0);
    end

    // 2: single bit 0->1, busy on edges 3..9, output at edge 10.
    do_reset(4'h0, 2);
    for (int e = 0; e < 6; e++) step(4'h0, "t2_idle");
    for (int e = 1; e <= 11; e++) begin
      step(4'h1, "t2");
      check("t2.busy", {3'b000, busy}, (e >= 3 && e <= 9) ? 4'h1 : 4'h0);
      check("t2.db0", {3'b000, db_out[0]}, (e >= 10) ? 4'h1 : 4'h0);
      check("t2.rise0", {3'b000, rise[0]}, (e == 10) ? 4'h1 : 4'h0);
    end

    // 3: bit 1 toggling every 3 cycles never propagates; then a full hold does.
    n_rise = 0;
    n_fall = 0;
    for (int c = 0; c < 60; c++) step(((c / 3) % 2 == 0) ? 4'h3 : 4'h1, "t3_tog");
    check("t3.no_pulse", 4'(n_rise + n_fall), 4'h0);
    check("t3.db1_hold", {3'b000, db_out[1]}, 4'h0);
    for (int c = 0; c < 14; c++) step(4'h3, "t3_hold");
    check("t3.one_rise", 4'(n_rise), 4'h1);

    // 4: bit 2 high 7 cycles (one short) then high 8 cycles.
    n_rise = 0;
    n_fall = 0;
    for (int c = 0; c < 7; c++) step(4'h7, "t4_short");
    for (int c = 0; c < 12; c++) step(4'h3, "t4_low");
    check("t4.short_none", 4'(n_rise + n_fall), 4'h0);
    for (int c = 0; c < 8; c++) step(4'h7, "t4_full");
    for (int c = 0; c < 14; c++) step(4'h3, "t4_low2");
    check("t4.rise", 4'(n_rise), 4'h1);
    check("t4.fall", 4'(n_fall), 4'h1);

    // 5: 0101 -> 1010 in one edge; all four pulses on edge 10.
    for (int c = 0; c < 12; c++) step(4'h5, "t5_pre");
    check("t5.pre_db", db_out, 4'h5);
    for (int e = 1; e <= 11; e++) begin
      step(4'hA, "t5");
      check("t5.rise", rise, (e == 10) ? 4'hA : 4'h0);
      check("t5.fall", fall, (e == 10) ? 4'h5 : 4'h0);
    end

    // 6: reset during a pending change, then full re-debounce.
    for (int e = 1; e <= 5; e++) step(4'hB, "t6_pend");
    do_reset(4'hB, 3);
    for (int e = 1; e <= 11; e++) begin
      step(4'hB, "t6");
      check("t6.rise", rise, (e == 10) ? 4'hB : 4'h0);
      check("t6.db_out", db_out, (e >= 10) ? 4'hB : 4'h0);
    end

    // Random bounce: each bit holds a random level for 1..12 cycles.
    for (int i = 0; i < W; i++) hold[i] = 0;
    rnd = raw_in;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < W; i++) begin
        if (hold[i] == 0) begin
          rnd[i]  = 1'($urandom_range(0, 1));
          hold[i] = int'($urandom_range(1, 12));
        end else begin
          hold[i]--;
        end
      end
      step(rnd, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
